// File: rtl/wb_pipe_reg_if.sv
// MEM->WB stage bus: upstream slot transfer, downstream head slot and fill level.
// The master side is the producer/consumer pair around the stage; slave is the stage itself.
interface wb_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5,
    parameter int CTRL_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_mem_data;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic [IDX_W-1:0]  in_rd;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_mem_data;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [IDX_W-1:0]  out_rd;

    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_mem_data, in_data, in_ctrl, in_rd, out_ready,
        input  in_ready, out_valid, out_mem_data, out_data, out_ctrl, out_rd, occupancy
    );

    modport slave (
        input  in_valid, in_mem_data, in_data, in_ctrl, in_rd, out_ready,
        output in_ready, out_valid, out_mem_data, out_data, out_ctrl, out_rd, occupancy
    );
endinterface

// File: rtl/wb_pipe_reg.sv
// MEM->WB pipeline register with a 2-entry skid buffer (main + skid), registered
// in_ready, synchronous flush and bubble-gated control bits.
module wb_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5,
    parameter int CTRL_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    wb_pipe_reg_if.slave    bus
);

    typedef struct packed {
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
        logic [IDX_W-1:0]  rd;
    } slot_t;

    slot_t main_q, main_nxt;
    slot_t skid_q, skid_nxt;
    logic  main_vld, main_vld_nxt;
    logic  skid_vld, skid_vld_nxt;
    logic  ready_q;
    slot_t in_slot;
    logic  accept, release_head;

    assign in_slot      = '{mem_data: bus.in_mem_data, data: bus.in_data,
                            ctrl: bus.in_ctrl, rd: bus.in_rd};
    assign accept       = bus.in_valid & ready_q;
    assign release_head = main_vld & bus.out_ready;

    // skid_vld implies main_vld, so the three branches cover occupancy 0/1/2.
    always_comb begin
        main_nxt     = main_q;
        skid_nxt     = skid_q;
        main_vld_nxt = main_vld;
        skid_vld_nxt = skid_vld;
        if (flush) begin
            main_vld_nxt = 1'b0;
            skid_vld_nxt = 1'b0;
        end else if (!main_vld) begin
            if (accept) begin
                main_nxt     = in_slot;
                main_vld_nxt = 1'b1;
            end
        end else if (!skid_vld) begin
            if (accept && release_head) begin
                main_nxt = in_slot;
            end else if (accept) begin
                skid_nxt     = in_slot;
                skid_vld_nxt = 1'b1;
            end else if (release_head) begin
                main_vld_nxt = 1'b0;
            end
        end else if (release_head) begin
            main_nxt     = skid_q;
            skid_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            main_q   <= main_nxt;
            skid_q   <= skid_nxt;
            main_vld <= main_vld_nxt;
            skid_vld <= skid_vld_nxt;
            ready_q  <= !skid_vld_nxt;
        end
    end

    // Control bits are gated so a bubble can never issue a register write.
    assign bus.in_ready     = ready_q;
    assign bus.out_valid    = main_vld;
    assign bus.out_mem_data = main_q.mem_data;
    assign bus.out_data     = main_q.data;
    assign bus.out_ctrl     = main_vld ? main_q.ctrl : '0;
    assign bus.out_rd       = main_q.rd;
    assign bus.occupancy    = {1'b0, main_vld} + {1'b0, skid_vld};

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed bench for wb_pipe_reg: reset, streaming, skid fill/drain, flush,
// bubble gating and asynchronous reset with the skid full.
module tb_wb_pipe_reg;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;
    localparam int CTRL_W = 2;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   n_cmp = 0;
    int   n_err = 0;

    wb_pipe_reg_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .CTRL_W(CTRL_W)) bus ();

    wb_pipe_reg #(.DATA_W(DATA_W), .IDX_W(IDX_W), .CTRL_W(CTRL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [31:0] m,
                         input logic [4:0] rd, input logic [1:0] c);
        bus.in_valid    = v;
        bus.in_data     = d;
        bus.in_mem_data = m;
        bus.in_rd       = rd;
        bus.in_ctrl     = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [31:0] d,
                            input logic [31:0] m, input logic [4:0] rd, input logic [1:0] c,
                            input logic [1:0] occ, input logic rdy);
        chk({tag, ".valid"}, bus.out_valid, v);
        chk({tag, ".data"},  bus.out_data, d);
        chk({tag, ".mem"},   bus.out_mem_data, m);
        chk({tag, ".rd"},    bus.out_rd, rd);
        chk({tag, ".ctrl"},  bus.out_ctrl, c);
        chk({tag, ".occ"},   bus.occupancy, occ);
        chk({tag, ".ready"}, bus.in_ready, rdy);
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, '0);

        // Reset and idle
        step();
        step();
        chk_head("rst", 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk_head("idle", 0, 0, 0, 0, 0, 0, 1);

        // Streaming: each slot one cycle later, occupancy 1 throughout
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i), 32'h100 + 32'(i), 5'(i), 2'b01);
            step();
            chk_head($sformatf("stream%0d", i), 1, 32'(i), 32'h100 + 32'(i), 5'(i), 2'b01, 1, 1);
        end
        drive(1'b0, '0, '0, '0, '0);
        step();
        chk_head("stream_end", 0, 7, 32'h107, 7, 0, 0, 1);

        // Skid fill: A held, B absorbed into skid, then drained in order
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hA, 32'h1A, 5'd10, 2'b01);
        step();
        chk_head("skidA", 1, 32'hA, 32'h1A, 10, 2'b01, 1, 1);
        drive(1'b1, 32'hB, 32'h1B, 5'd11, 2'b11);
        step();
        chk_head("skidAB", 1, 32'hA, 32'h1A, 10, 2'b01, 2, 0);
        drive(1'b0, '0, '0, '0, '0);
        step();
        chk_head("skid_hold", 1, 32'hA, 32'h1A, 10, 2'b01, 2, 0);
        bus.out_ready = 1'b1;
        step();
        chk_head("drainB", 1, 32'hB, 32'h1B, 11, 2'b11, 1, 1);
        step();
        // Bubble gating: B had ctrl=11, now released with no new accept
        chk_head("bubble", 0, 32'hB, 32'h1B, 11, 2'b00, 0, 1);

        // Flush at occupancy 2 with slot C offered
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hD, 32'h1D, 5'd13, 2'b01);
        step();
        drive(1'b1, 32'hE, 32'h1E, 5'd14, 2'b01);
        step();
        chk_head("preflush", 1, 32'hD, 32'h1D, 13, 2'b01, 2, 0);
        flush = 1'b1;
        drive(1'b1, 32'hC, 32'h1C, 5'd12, 2'b11);
        step();
        chk("flush2.valid", bus.out_valid, 0);
        chk("flush2.ctrl",  bus.out_ctrl, 0);
        chk("flush2.occ",   bus.occupancy, 0);
        chk("flush2.ready", bus.in_ready, 1);
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        bus.out_ready = 1'b1;
        step();
        chk("flush2.noC", bus.out_valid, 0);

        // Flush at occupancy 1 where the offered slot would otherwise be accepted
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hF, 32'h1F, 5'd15, 2'b01);
        step();
        chk_head("preflush1", 1, 32'hF, 32'h1F, 15, 2'b01, 1, 1);
        flush = 1'b1;
        drive(1'b1, 32'h77, 32'h177, 5'd7, 2'b01);
        step();
        chk("flush1.valid", bus.out_valid, 0);
        chk("flush1.occ",   bus.occupancy, 0);
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        step();
        chk("flush1.noslot", bus.out_valid, 0);

        // Asynchronous reset between edges with occupancy 2
        drive(1'b1, 32'h60, 32'h160, 5'd20, 2'b11);
        step();
        drive(1'b1, 32'h61, 32'h161, 5'd21, 2'b01);
        step();
        chk("prereset.occ", bus.occupancy, 2);
        drive(1'b0, '0, '0, '0, '0);
        #1;
        reset = 1'b0;
        #1;
        chk_head("areset", 0, 0, 0, 0, 0, 0, 1);
        #1;
        reset = 1'b1;

        // Streaming resumes
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h55, 32'h155, 5'd5, 2'b01);
        step();
        chk_head("resume0", 1, 32'h55, 32'h155, 5, 2'b01, 1, 1);
        drive(1'b1, 32'h66, 32'h166, 5'd6, 2'b10);
        step();
        chk_head("resume1", 1, 32'h66, 32'h166, 6, 2'b10, 1, 1);
        drive(1'b0, '0, '0, '0, '0);
        step();
        chk_head("resume_end", 0, 32'h66, 32'h166, 6, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_pipe_reg.md
# wb_pipe_reg

Parametrised MEM→WB pipeline stage register that supersedes the plain enable-gated stage flops. The design adds a valid/ready handshake with a 2-entry skid buffer, so that `in_ready` is driven from a register and back-pressure does not form a combinational path through the stage. It also adds a synchronous flush, and it gates the control bits on bubbles so that a register write can never be issued by an invalid slot. It sits between the memory stage and the register-file write port.

## Interface
- `DATA_W`, 32, width of each data word (memory read data and ALU result)
- `IDX_W`, 5, width of the destination register index
- `CTRL_W`, 2, width of the control vector (bit0 = write_reg, bit1 = ld_ins)
- `clk` input 1 — single clock; all state updates on the rising edge
- `reset` input 1 — asynchronous, active-low; clears all state immediately when low
- `flush` input 1 — synchronous kill of every held entry
- `in_valid` input 1 — upstream has a slot to transfer
- `in_ready` output 1 — stage can accept a slot; registered output
- `in_mem_data` input DATA_W — memory read data
- `in_data` input DATA_W — ALU/forwarded result
- `in_ctrl` input CTRL_W — control vector
- `in_rd` input IDX_W — destination register index
- `out_valid` output 1 — head slot is valid
- `out_ready` input 1 — downstream consumes the head slot
- `out_mem_data` output DATA_W — head slot memory data
- `out_data` output DATA_W — head slot result
- `out_ctrl` output CTRL_W — head slot control, forced to 0 when `out_valid`=0
- `out_rd` output IDX_W — head slot destination index
- `occupancy` output 2 — number of held slots (0, 1 or 2)

## Operation
- Storage consists of a main entry (which drives the `out_*` ports) and a skid entry. Each entry holds the full payload plus a valid bit.
- Transfer events:
  - Accept: `in_valid & in_ready`.
  - Release: `out_valid & out_ready`.
- `in_ready` = !skid_valid, taken from the register state and not from `out_ready`.
- Per-cycle transitions (no flush):
  - **Occupancy 0, accept:** the payload loads into main; occupancy goes to 1.
  - **Occupancy 1, accept and release:** main is overwritten with the new payload; occupancy stays at 1.
  - **Occupancy 1, accept without release:** the payload loads into skid; occupancy goes to 2, so `in_ready`=0 on the next cycle.
  - **Occupancy 1, release without accept:** main is invalidated; occupancy goes to 0.
  - **Occupancy 2, release:** main receives the skid contents and skid is invalidated; occupancy goes to 1 and `in_ready` returns to 1. No accept is possible in this state.
  - **Occupancy 2, no release:** the stage holds.
- Slot order is strictly FIFO. No slot is lost or duplicated.
- Flush has the highest priority:
  - Both valid bits clear on the next edge.
  - Any accept in the flush cycle is discarded.
  - A release in the flush cycle still counts for downstream, since the head was presented.
  - Payload registers may retain their old values. `out_ctrl` reads 0 because of bubble gating.
- `out_mem_data`, `out_data` and `out_rd` hold their last value while `out_valid`=0. Downstream must qualify them with `out_valid`.
- `occupancy` = main_valid + skid_valid.
- Behaviour is undefined for `in_valid`=1 with X on the payload. There is no internal checking.

## Timing
- **Reset (reset=0):**
  - `out_valid`=0, `out_ctrl`=0, `out_mem_data`=0, `out_data`=0, `out_rd`=0.
  - `occupancy`=0, `in_ready`=1.
  - Skid contents are 0.
- Reset deassertion is synchronised by the rest of the design. On the first edge with reset=1, the stage can already accept.
- **Latency:** a slot accepted at edge N appears at `out_*` with `out_valid`=1 after edge N (1 cycle) when the stage is empty or releasing.
- **Throughput:** 1 slot/cycle while `out_ready`=1.
- **Back-pressure:**
  - When `out_ready` drops, at most one further slot is absorbed (into skid).
  - `in_ready` falls one cycle later.
  - `in_ready` rises in the cycle after the first release from occupancy 2.
- **Reset asserted mid-transfer:** all state clears asynchronously, and in-flight slots are dropped.

## Test plan
- **Reset and idle:**
  - Stimulus: hold reset=0, then release it with `in_valid`=0.
  - Required: `out_valid`=0, `out_ctrl`=0, all data outputs 0, `in_ready`=1, `occupancy`=0.
- **Streaming:**
  - Stimulus: `out_ready`=1; drive 8 consecutive slots with `in_data`=i, `in_mem_data`=0x100+i, `in_rd`=i, `in_ctrl`=2'b01.
  - Required: each slot appears one cycle later, in order, with `occupancy`=1 throughout.
- **Skid fill:**
  - Stimulus: slot A is held (`out_ready`=0); push slot B.
  - Required: `occupancy`=2 and `in_ready`=0 next cycle. When `out_ready`=1 for two cycles, A and then B are released, and `in_ready`=1 after the first release.
- **Flush with occupancy 2, `in_valid`=1 (slot C):**
  - Required: next cycle `out_valid`=0, `out_ctrl`=0, `occupancy`=0, `in_ready`=1. C never appears.
- **Bubble gating:**
  - Stimulus: after a release with `in_ctrl`=2'b11 and no new accept.
  - Required: `out_ctrl`=2'b00 while `out_valid`=0, and `out_data` still equals the last value.
- **Asynchronous reset mid-stream:**
  - Stimulus: pulse reset low between edges while `occupancy`=2.
  - Required: all outputs are at their reset values before the next edge, and streaming resumes correctly afterwards.
